// File: rtl/alu_mult_pipe_if.sv
// Valid/ack data stream shared by the scheduler's ALU units.
// Transfer happens on a rising edge with valid and ack both high.
interface data_interface #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ack;

  modport producer (output data, output valid, input ack);
  modport consumer (input data, input valid, output ack);
endinterface

// File: rtl/alu_mult_pipe.sv
// Pipelined MUL/MULS unit with credit-issued output buffer.
// Define ALU_MULT_PERF_EN to add perf_issued/perf_stalled counters.
module alu_mult_pipe #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    OPCODE_WIDTH = 6,
  parameter logic [OPCODE_WIDTH-1:0] ALU_OP_MUL  = OPCODE_WIDTH'(16),
  parameter logic [OPCODE_WIDTH-1:0] ALU_OP_MULS = OPCODE_WIDTH'(17),
  parameter int                    PIPE_STAGES  = 3,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  data_interface.consumer operator,
  data_interface.consumer left,
  data_interface.consumer right,
  data_interface.producer result,
  data_interface.producer overflow
`ifdef ALU_MULT_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stalled
`endif
);

  localparam int PWID = 2 * DATA_WIDTH;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  logic [OPCODE_WIDTH-1:0] opc;
  logic                    is_signed;
  logic                    match;
  logic                    all_valid;
  logic                    pop;
  logic                    accept;
  logic                    wr;
  logic [PWID-1:0]         a_ext;
  logic [PWID-1:0]         b_ext;
  logic [PWID-1:0]         prod;

  logic [PIPE_STAGES-1:0]  vld_q;
  logic [PWID-1:0]         prod_q [PIPE_STAGES];
  logic [PWID-1:0]         mem_q  [FIFO_DEPTH];
  logic [PW-1:0]           wr_q;
  logic [PW-1:0]           rd_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           occ_q;

  assign opc       = operator.data[OPCODE_WIDTH-1:0];
  assign is_signed = (opc == ALU_OP_MULS);
  assign match     = (opc == ALU_OP_MUL) | is_signed;
  assign all_valid = operator.valid & left.valid & right.valid & match;
  assign pop       = (cnt_q != '0) & result.ack & overflow.ack;

  // occ_q is the credit count: in-flight stages plus buffered entries
  assign accept = reset_n & all_valid & ((occ_q < DEPTH_C) | pop);

  assign operator.ack = accept;
  assign left.ack     = accept;
  assign right.ack    = accept;

  assign a_ext = is_signed ? {{DATA_WIDTH{left.data[DATA_WIDTH-1]}}, left.data}
                           : {{DATA_WIDTH{1'b0}}, left.data};
  assign b_ext = is_signed ? {{DATA_WIDTH{right.data[DATA_WIDTH-1]}}, right.data}
                           : {{DATA_WIDTH{1'b0}}, right.data};
  assign prod  = a_ext * b_ext;
  assign wr    = vld_q[PIPE_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      if (accept) prod_q[0] <= prod;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      occ_q <= occ_q + CW'(accept) - CW'(pop);
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
      if (wr) begin
        mem_q[wr_q] <= prod_q[PIPE_STAGES-1];
        wr_q        <= (wr_q == LAST_C) ? '0 : wr_q + PW'(1);
      end
      if (pop) rd_q <= (rd_q == LAST_C) ? '0 : rd_q + PW'(1);
    end
  end

  assign result.valid   = (cnt_q != '0);
  assign overflow.valid = (cnt_q != '0);
  assign result.data    = mem_q[rd_q][DATA_WIDTH-1:0];
  assign overflow.data  = mem_q[rd_q][PWID-1:DATA_WIDTH];

`ifdef ALU_MULT_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued  <= '0;
      perf_stalled <= '0;
    end else begin
      if (accept) perf_issued <= perf_issued + 32'd1;
      if (all_valid & !accept) perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_mult_pipe.sv
// Directed scoreboard bench for alu_mult_pipe.
// Expected products are queued at accept and checked at pop.
module tb_alu_mult_pipe;
  localparam int W = 32;
  localparam logic [5:0] OP_MUL  = 6'd16;
  localparam logic [5:0] OP_MULS = 6'd17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_interface #(.WIDTH(W)) op_if();
  data_interface #(.WIDTH(W)) l_if();
  data_interface #(.WIDTH(W)) r_if();
  data_interface #(.WIDTH(W)) res_if();
  data_interface #(.WIDTH(W)) ovf_if();

`ifdef ALU_MULT_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stalled;
`endif

  alu_mult_pipe dut (
    .clock    (clk),
    .reset_n  (rst_n),
    .operator (op_if),
    .left     (l_if),
    .right    (r_if),
    .result   (res_if),
    .overflow (ovf_if)
`ifdef ALU_MULT_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stalled (perf_stalled)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [2*W-1:0] sb[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst_n && res_if.valid && res_if.ack && ovf_if.ack) begin
      pop_cyc.push_back(cyc);
      check("pop_sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", 64'(res_if.data), 64'(e[W-1:0]));
        check("overflow", 64'(ovf_if.data), 64'(e[2*W-1:W]));
      end
    end
  end

  task automatic set_valid(input logic v);
    op_if.valid = v;
    l_if.valid  = v;
    r_if.valid  = v;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp,
                       output int acc);
    int n;
    n = 0;
    op_if.data = 32'(op);
    l_if.data  = a;
    r_if.data  = b;
    set_valid(1'b1);
    @(negedge clk);
    while (!op_if.ack && n < 50) begin
      n++;
      @(negedge clk);
    end
    acc = cyc;
    check("issue_acked", 64'(op_if.ack), 64'd1);
    if (op_if.ack) sb.push_back(exp);
    @(posedge clk); #1;
    set_valid(1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int acc0;
    int n;
    int nacc;
    res_if.ack = 1'b0;
    ovf_if.ack = 1'b0;
    op_if.data = 32'(OP_MUL);
    l_if.data  = '0;
    r_if.data  = '0;
    set_valid(1'b0);

    #1 set_valid(1'b1);
    repeat (2) @(negedge clk);
    check("rst_res_valid", 64'(res_if.valid), 64'd0);
    check("rst_ovf_valid", 64'(ovf_if.valid), 64'd0);
    check("rst_ack", 64'(op_if.ack), 64'd0);
    set_valid(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_if.ack = 1'b1;
    ovf_if.ack = 1'b1;

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, acc);
    n = 0;
    @(negedge clk);
    while (!res_if.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mul_latency", 64'(cyc - acc), 64'd4);
    drain();

    issue(OP_MULS, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, acc);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, acc);
    drain();

    pop_cyc.delete();
    acc0 = 0;
    for (int i = 0; i < 8; i++) begin
      issue(OP_MUL, 32'(i), 32'(i + 1), 64'(i * (i + 1)), acc);
      if (i == 0) acc0 = acc;
    end
    check("b2b_in_consec", 64'(acc - acc0), 64'd7);
    drain();
    check("b2b_out_count", 64'(pop_cyc.size()), 64'd8);
    check("b2b_out_consec", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    res_if.ack = 1'b0;
    ovf_if.ack = 1'b0;
    op_if.data = 32'(OP_MUL);
    l_if.data  = 32'd100;
    set_valid(1'b1);
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      r_if.data = 32'(i);
      @(negedge clk);
      if (op_if.ack) begin
        sb.push_back(64'(100 * i));
        nacc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", 64'(nacc), 64'd4);
    @(negedge clk);
    check("bp_ack_low", 64'(op_if.ack), 64'd0);
    check("bp_valid", 64'(res_if.valid), 64'd1);
    @(posedge clk); #1;
    res_if.ack = 1'b1;
    @(negedge clk);
    check("ovf_ack_low_no_accept", 64'(op_if.ack), 64'd0);
    @(posedge clk); #1;
    r_if.data  = 32'd50;
    ovf_if.ack = 1'b1;
    @(negedge clk);
    check("pop_and_accept", 64'(op_if.ack), 64'd1);
    if (op_if.ack) sb.push_back(64'd5000);
    @(posedge clk); #1;
    res_if.ack = 1'b0;
    ovf_if.ack = 1'b0;
    @(negedge clk);
    check("single_pop_ack_low", 64'(op_if.ack), 64'd0);
    @(posedge clk); #1;
    set_valid(1'b0);
    res_if.ack = 1'b1;
    ovf_if.ack = 1'b1;
    drain();

    op_if.data = 32'd5;
    l_if.data  = 32'd3;
    r_if.data  = 32'd4;
    set_valid(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("op5_ack", 64'(op_if.ack), 64'd0);
      check("op5_valid", 64'(res_if.valid), 64'd0);
      @(posedge clk); #1;
    end
    op_if.data = 32'(OP_MUL);
    l_if.data  = 32'd7;
    r_if.data  = 32'd9;
    @(negedge clk);
    check("op16_immediate", 64'(op_if.ack), 64'd1);
    if (op_if.ack) sb.push_back(64'd63);
    @(posedge clk); #1;
    set_valid(1'b0);
    drain();

    res_if.ack = 1'b0;
    ovf_if.ack = 1'b0;
    issue(OP_MUL, 32'd2, 32'd3, 64'd6, acc);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) issue(OP_MUL, 32'(i), 32'd5, 64'(i * 5), acc);
    check("mid_buffered", 64'(res_if.valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_res_valid", 64'(res_if.valid), 64'd0);
    check("async_ovf_valid", 64'(ovf_if.valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_if.ack = 1'b1;
    ovf_if.ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(res_if.valid), 64'd0);
    end
    @(posedge clk); #1;
    issue(OP_MULS, 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
